fp_align: RTL and testbench

Exponent-compare and mantissa-alignment stage of the floating-point adder. Sits directly upstream of the add stage that produces the 25-bit intermediate sum for normalisation. It accepts two IEEE-754 single-precision operands, selects the larger exponent, and right-shifts the smaller operand's mantissa one bit per cycle under an FSM. It hands the aligned pair, signs, select flag and effective-subtract flag downstream over a valid/ready handshake.

---
 rtl/fp_pkg.sv | 26 ++
 rtl/fp_unpack.sv | 26 ++
 rtl/fp_align.sv | 174 +++++++++++++++++
 tb/tb_fp_align.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants, FSM state encoding and unpacked-operand record for the
// floating-point adder front end.
package fp_pkg;

  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int BIAS      = 127;
  localparam int MAX_SHIFT = 24;
  // Wide enough to hold MAX_SHIFT
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } align_state_t;

  // Operand after field split: effective exponent (zero exponent reads as 1)
  // and mantissa with the hidden bit restored.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] eff_exp;
    logic [MAN_W:0]   man;
  } unpacked_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational split of an IEEE-754 single into sign, effective exponent and
// mantissa with hidden bit. A zero exponent field (zero/denormal) is given
// effective exponent 1 and a hidden bit of 0.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0] i_op,
  output unpacked_t   o_op
);

  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_frac;
  logic             w_hidden;

  assign w_exp    = i_op[30:23];
  assign w_frac   = i_op[22:0];
  assign w_hidden = (w_exp != '0);

  // Assemble the unpacked record
  always_comb begin
    o_op.sign    = i_op[31];
    o_op.eff_exp = w_hidden ? w_exp : EXP_W'(1);
    o_op.man     = {w_hidden, w_frac};
  end

endmodule

// File: rtl/fp_align.sv
// Exponent compare and mantissa alignment for the FP adder. The smaller
// exponent's mantissa is shifted right one bit per cycle (at most 24 cycles)
// and the aligned pair is offered downstream over valid/ready.
// Optional feature: define FP_ALIGN_STICKY_EN to add the sticky output that
// ORs every shifted-out bit; without it shifted-out bits are truncated.
module fp_align
  import fp_pkg::*;
#(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int MAN_W = fp_pkg::MAN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             s,
  output logic             sign_a,
  output logic             sign_b,
  output logic             xor_op,
  output logic [EXP_W-1:0] ex,
  output logic [MAN_W:0]   man_a,
  output logic [MAN_W:0]   man_b
`ifdef FP_ALIGN_STICKY_EN
  ,
  output logic             sticky
`endif
);

  align_state_t     r_state;
  align_state_t     w_state_nxt;

  unpacked_t        w_ua;
  unpacked_t        w_ub;

  logic             w_a_ge_b;
  logic [EXP_W:0]   w_diff;
  logic [CNT_W-1:0] w_cnt_init;
  logic             w_capture;
  logic             w_shift_lsb;

  logic [CNT_W-1:0] r_cnt;
  logic             r_s;
  logic             r_sign_a;
  logic             r_sign_b;
  logic [EXP_W-1:0] r_ex;
  logic [MAN_W:0]   r_man_a;
  logic [MAN_W:0]   r_man_b;
`ifdef FP_ALIGN_STICKY_EN
  logic             r_sticky;
`endif

  fp_unpack u_unpack_a (
    .i_op (a),
    .o_op (w_ua)
  );

  fp_unpack u_unpack_b (
    .i_op (b),
    .o_op (w_ub)
  );

  // Exponent compare, difference and clamped shift count
  always_comb begin
    w_a_ge_b = (w_ua.eff_exp >= w_ub.eff_exp);
    if (w_a_ge_b) begin
      w_diff = {1'b0, w_ua.eff_exp} - {1'b0, w_ub.eff_exp};
    end else begin
      w_diff = {1'b0, w_ub.eff_exp} - {1'b0, w_ua.eff_exp};
    end
    if (w_diff >= (EXP_W+1)'(MAX_SHIFT)) begin
      w_cnt_init = CNT_W'(MAX_SHIFT);
    end else begin
      w_cnt_init = w_diff[CNT_W-1:0];
    end
  end

  assign w_capture   = (r_state == IDLE) && in_valid;
  // Bit leaving the shifted (smaller-exponent) mantissa this cycle
  assign w_shift_lsb = r_s ? r_man_b[0] : r_man_a[0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_nxt = (w_cnt_init == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture and one-bit-per-cycle alignment of the smaller mantissa
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_s      <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_ex     <= '0;
      r_man_a  <= '0;
      r_man_b  <= '0;
    end else if (w_capture) begin
      r_cnt    <= w_cnt_init;
      r_s      <= w_a_ge_b;
      r_sign_a <= w_ua.sign;
      r_sign_b <= w_ub.sign;
      r_ex     <= w_a_ge_b ? w_ua.eff_exp : w_ub.eff_exp;
      r_man_a  <= w_ua.man;
      r_man_b  <= w_ub.man;
    end else if (r_state == SHIFT) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_s) begin
        r_man_b <= {1'b0, r_man_b[MAN_W:1]};
      end else begin
        r_man_a <= {1'b0, r_man_a[MAN_W:1]};
      end
    end
  end

`ifdef FP_ALIGN_STICKY_EN
  // Sticky accumulation: cleared on capture, ORs each shifted-out bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_capture) begin
      r_sticky <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_sticky <= r_sticky | w_shift_lsb;
    end
  end

  assign sticky = r_sticky;
`else
  // Without the sticky feature the shifted-out bit is simply dropped
  logic w_unused_lsb;
  assign w_unused_lsb = w_shift_lsb;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign s         = r_s;
  assign sign_a    = r_sign_a;
  assign sign_b    = r_sign_b;
  assign xor_op    = r_sign_a ^ r_sign_b;
  assign ex        = r_ex;
  assign man_a     = r_man_a;
  assign man_b     = r_man_b;

endmodule

// File: tb/tb_fp_align.sv
// Directed self-checking bench for fp_align. Honours FP_ALIGN_STICKY_EN when
// the design is built with it.
module tb_fp_align;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic        s;
  logic        sign_a;
  logic        sign_b;
  logic        xor_op;
  logic [7:0]  ex;
  logic [23:0] man_a;
  logic [23:0] man_b;
`ifdef FP_ALIGN_STICKY_EN
  logic        sticky;
`endif

  int n_pass = 0;
  int n_fail = 0;

  fp_align dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .xor_op    (xor_op),
    .ex        (ex),
    .man_a     (man_a),
    .man_b     (man_b)
`ifdef FP_ALIGN_STICKY_EN
    ,
    .sticky    (sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands for one cycle; returns just after the capture edge
  task automatic send(input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges from capture until out_valid (bounded)
  task automatic wait_done(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
  endtask

  // Accept the result and verify return to IDLE
  task automatic drain(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_ovalid_clr"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_iready_set"}, {31'd0, in_ready}, 32'd1);
  endtask

  logic [23:0] hold_ma;
  logic [23:0] hold_mb;
  logic [7:0]  hold_ex;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    chk("rst_iready", {31'd0, in_ready}, 32'd1);
    chk("rst_ovalid", {31'd0, out_valid}, 32'd0);
    chk("rst_ex", {24'd0, ex}, 32'd0);
    chk("rst_man_a", {8'd0, man_a}, 32'd0);
    chk("rst_man_b", {8'd0, man_b}, 32'd0);
    chk("rst_s", {31'd0, s}, 32'd0);
`ifdef FP_ALIGN_STICKY_EN
    chk("rst_sticky", {31'd0, sticky}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Case 1: 1.0 + 1.0, d=0
    send(32'h3F800000, 32'h3F800000);
    wait_done("c1", 0);
    chk("c1_ex", {24'd0, ex}, 32'h7F);
    chk("c1_man_a", {8'd0, man_a}, 32'h800000);
    chk("c1_man_b", {8'd0, man_b}, 32'h800000);
    chk("c1_s", {31'd0, s}, 32'd1);
    chk("c1_xor", {31'd0, xor_op}, 32'd0);
    drain("c1");

    // Case 2: 1.0 + 0.5, d=1
    send(32'h3F800000, 32'h3F000000);
    chk("c2_iready_busy", {31'd0, in_ready}, 32'd0);
    wait_done("c2", 1);
    chk("c2_ex", {24'd0, ex}, 32'h7F);
    chk("c2_man_a", {8'd0, man_a}, 32'h800000);
    chk("c2_man_b", {8'd0, man_b}, 32'h400000);
    chk("c2_s", {31'd0, s}, 32'd1);
    drain("c2");

    // Case 3: -3.0 + 1.0, d=1, then backpressure
    send(32'hC0400000, 32'h3F800000);
    wait_done("c3", 1);
    chk("c3_ex", {24'd0, ex}, 32'h80);
    chk("c3_man_a", {8'd0, man_a}, 32'hC00000);
    chk("c3_man_b", {8'd0, man_b}, 32'h400000);
    chk("c3_sign_a", {31'd0, sign_a}, 32'd1);
    chk("c3_sign_b", {31'd0, sign_b}, 32'd0);
    chk("c3_xor", {31'd0, xor_op}, 32'd1);
    chk("c3_s", {31'd0, s}, 32'd1);
    hold_ma = man_a;
    hold_mb = man_b;
    hold_ex = ex;
    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'h3F000000;
    b        = 32'h40800000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_ovalid", {31'd0, out_valid}, 32'd1);
      chk("bp_iready", {31'd0, in_ready}, 32'd0);
      chk("bp_man_a", {8'd0, man_a}, {8'd0, hold_ma});
      chk("bp_man_b", {8'd0, man_b}, {8'd0, hold_mb});
      chk("bp_ex", {24'd0, ex}, {24'd0, hold_ex});
    end
    in_valid = 1'b0;
    drain("bp");
    @(posedge clk);
    #1;
    chk("bp_no_capture", {31'd0, in_ready}, 32'd1);

    // Case 4: 1.0 + tiny, d=30 clamped to 24
    send(32'h3F800000, 32'h30800000);
    wait_done("c4", 24);
    chk("c4_ex", {24'd0, ex}, 32'h7F);
    chk("c4_man_a", {8'd0, man_a}, 32'h800000);
    chk("c4_man_b", {8'd0, man_b}, 32'h000000);
`ifdef FP_ALIGN_STICKY_EN
    chk("c4_sticky", {31'd0, sticky}, 32'd1);
`endif
    drain("c4");

    // Case 5: b larger (s=0), a's mantissa is the shifted one
    send(32'h3F000000, 32'h3F800000);
    wait_done("c5", 1);
    chk("c5_s", {31'd0, s}, 32'd0);
    chk("c5_ex", {24'd0, ex}, 32'h7F);
    chk("c5_man_a", {8'd0, man_a}, 32'h400000);
    chk("c5_man_b", {8'd0, man_b}, 32'h800000);
`ifdef FP_ALIGN_STICKY_EN
    chk("c5_sticky", {31'd0, sticky}, 32'd0);
`endif
    drain("c5");

    // Case 6: denormal vs min normal, both effective exponent 1
    send(32'h80000001, 32'h00800000);
    wait_done("c6", 0);
    chk("c6_ex", {24'd0, ex}, 32'h01);
    chk("c6_man_a", {8'd0, man_a}, 32'h000001);
    chk("c6_man_b", {8'd0, man_b}, 32'h800000);
    chk("c6_s", {31'd0, s}, 32'd1);
    chk("c6_xor", {31'd0, xor_op}, 32'd1);
    drain("c6");

    // Case 7: reset during SHIFT aborts
    send(32'h3F800000, 32'h30800000);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_iready", {31'd0, in_ready}, 32'd1);
    chk("ar_ovalid", {31'd0, out_valid}, 32'd0);
    chk("ar_ex", {24'd0, ex}, 32'd0);
    chk("ar_man_a", {8'd0, man_a}, 32'd0);
    chk("ar_man_b", {8'd0, man_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(32'h3F800000, 32'h3F000000);
    wait_done("c8", 1);
    chk("c8_man_a", {8'd0, man_a}, 32'h800000);
    chk("c8_man_b", {8'd0, man_b}, 32'h400000);
    chk("c8_ex", {24'd0, ex}, 32'h7F);
    drain("c8");

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
